// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared pipelined 4x4 signed multiplier.
// Grants one operand pair per cycle, tracks ownership through the pipe and returns tagged results.
module mult_arbiter #(
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_res,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  logic               last_id;
  logic               grant0;
  logic               grant1;
  logic               issue_valid;
  logic               issue_id;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;
  logic               tag_out_valid;
  logic               tag_out_id;

  // On a tie the requester that did not win most recently gets the slot.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_id;
        grant1 = !last_id;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready    = grant0;
  assign req1_ready    = grant1;
  assign tag_out_valid = tag_valid[LATENCY-1];
  assign tag_out_id    = tag_id[LATENCY-1];

  // The issue tag sits beside mul_a/mul_b; the chain behind it tracks the
  // multiplier's LATENCY stages so the tag exits exactly when mul_res is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id     <= 1'b1;
      mul_a       <= 4'd0;
      mul_b       <= 4'd0;
      issue_valid <= 1'b0;
      issue_id    <= 1'b0;
      tag_valid   <= '0;
      tag_id      <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp_data    <= 8'd0;
      cnt0        <= 8'd0;
      cnt1        <= 8'd0;
    end else begin
      if (grant0 || grant1) begin
        last_id <= grant1;
      end
      if (grant0) begin
        mul_a <= req0_a;
        mul_b <= req0_b;
      end else if (grant1) begin
        mul_a <= req1_a;
        mul_b <= req1_b;
      end else begin
        mul_a <= 4'd0;
        mul_b <= 4'd0;
      end
      issue_valid  <= grant0 || grant1;
      issue_id     <= grant1;
      tag_valid[0] <= issue_valid;
      tag_id[0]    <= issue_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      rsp0_valid <= tag_out_valid && !tag_out_id;
      rsp1_valid <= tag_out_valid && tag_out_id;
      if (tag_out_valid) begin
        rsp_data <= mul_res;
      end
      if (tag_out_valid && !tag_out_id && (cnt0 != 8'hFF)) begin
        cnt0 <= cnt0 + 8'd1;
      end
      if (tag_out_valid && tag_out_id && (cnt1 != 8'hFF)) begin
        cnt1 <= cnt1 + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: models the external multiplier pipe, applies a directed
// per-cycle vector table, then hand-written streaming, reset and saturation sequences.
module tb_mult_arbiter;
  localparam int LATENCY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_res;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_data, cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  mult_arbiter #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // External multiplier: LATENCY edges from mul_a/mul_b to mul_res.
  logic [7:0] mpipe [LATENCY];
  initial for (int i = 0; i < LATENCY; i++) mpipe[i] = 8'd0;
  always @(posedge clk) begin
    mpipe[0] <= 8'($signed(mul_a) * $signed(mul_b));
    for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_res = mpipe[LATENCY-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready_onehot", {31'd0, req0_ready && req1_ready}, 32'd0);
    chk("rsp_onehot", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
  end

  typedef struct {
    logic       v0;
    logic [3:0] a0, b0;
    logic       v1;
    logic [3:0] a1, b1;
    logic       er0, er1, ep0, ep1;
    logic [7:0] ed, ec0, ec1;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                              input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                              input logic er0, input logic er1, input logic ep0, input logic ep1,
                              input logic [7:0] ed, input logic [7:0] ec0, input logic [7:0] ec1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.er0 = er0; v.er1 = er1; v.ep0 = ep0; v.ep1 = ep1;
    v.ed = ed; v.ec0 = ec0; v.ec1 = ec1;
    return v;
  endfunction

  int  n0, n1, run1, max_run1;
  logic       chk_data;
  logic [7:0] exp_data;

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  // One cycle: sample responses at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    if (rsp0_valid) n0++;
    if (rsp1_valid) begin
      n1++;
      run1++;
      if (run1 > max_run1) max_run1 = run1;
    end else begin
      run1 = 0;
    end
    if (chk_data && (rsp0_valid || rsp1_valid)) chk("stream_data", {24'd0, rsp_data}, {24'd0, exp_data});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = 0; n1 = 0; run1 = 0; max_run1 = 0;
  endtask

  initial begin
    // rows: v0 a0 b0 | v1 a1 b1 | rdy0 rdy1 | rsp0 rsp1 | data cnt0 cnt1
    vecs[0]  = mk(1, 4'd3, 4'd4, 0, 4'd0, 4'd0, 1, 0, 0, 0, 8'h00, 8'd0, 8'd0);
    vecs[1]  = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 8'h00, 8'd0, 8'd0);
    vecs[2]  = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 8'h00, 8'd0, 8'd0);
    vecs[3]  = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 8'h00, 8'd0, 8'd0);
    vecs[4]  = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 8'h00, 8'd0, 8'd0);
    vecs[5]  = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 1, 0, 8'h0C, 8'd1, 8'd0);
    vecs[6]  = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 8'h0C, 8'd1, 8'd0);
    vecs[7]  = mk(0, 4'd0, 4'd0, 1, 4'd2, 4'd3, 0, 1, 0, 0, 8'h0C, 8'd1, 8'd0);
    vecs[8]  = mk(0, 4'd0, 4'd0, 1, 4'hE, 4'd3, 0, 1, 0, 0, 8'h0C, 8'd1, 8'd0);
    vecs[9]  = mk(1, 4'hF, 4'hF, 1, 4'hF, 4'd1, 1, 0, 0, 0, 8'h0C, 8'd1, 8'd0);
    vecs[10] = mk(1, 4'hF, 4'hF, 1, 4'hF, 4'd1, 0, 1, 0, 0, 8'h0C, 8'd1, 8'd0);
    vecs[11] = mk(1, 4'hF, 4'hF, 1, 4'hF, 4'd1, 1, 0, 0, 0, 8'h0C, 8'd1, 8'd0);
    vecs[12] = mk(1, 4'hF, 4'hF, 1, 4'hF, 4'd1, 0, 1, 0, 1, 8'h06, 8'd1, 8'd1);
    vecs[13] = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 1, 8'hFA, 8'd1, 8'd2);
    vecs[14] = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 1, 0, 8'h01, 8'd2, 8'd2);
    vecs[15] = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 1, 8'hFF, 8'd2, 8'd3);
    vecs[16] = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 1, 0, 8'h01, 8'd3, 8'd3);
    vecs[17] = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 1, 8'hFF, 8'd3, 8'd4);
    vecs[18] = mk(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 8'hFF, 8'd3, 8'd4);

    chk_data = 1'b0;
    exp_data = 8'd0;
    n0 = 0; n1 = 0; run1 = 0; max_run1 = 0;

    // Reset with both requesters valid: no grants while rst is high.
    rst = 1'b1;
    drive(1'b1, 4'd3, 4'd4, 1'b1, 4'd5, 4'd6);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("rst_mul_a", {28'd0, mul_a}, 32'd0);
    chk("rst_mul_b", {28'd0, mul_b}, 32'd0);
    chk("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("rst_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_cnt", {16'd0, cnt0, cnt1}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1);
      @(negedge clk);
      chk($sformatf("vec%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].er0});
      chk($sformatf("vec%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].er1});
      chk($sformatf("vec%0d_rsp0", i), {31'd0, rsp0_valid}, {31'd0, vecs[i].ep0});
      chk($sformatf("vec%0d_rsp1", i), {31'd0, rsp1_valid}, {31'd0, vecs[i].ep1});
      chk($sformatf("vec%0d_data", i), {24'd0, rsp_data}, {24'd0, vecs[i].ed});
      chk($sformatf("vec%0d_cnt0", i), {24'd0, cnt0}, {24'd0, vecs[i].ec0});
      chk($sformatf("vec%0d_cnt1", i), {24'd0, cnt1}, {24'd0, vecs[i].ec1});
      @(posedge clk);
      #1;
    end

    // req1 streams -2*-2 for 10 cycles: 10 back-to-back pulses of 0x04.
    do_reset();
    chk_data = 1'b1;
    exp_data = 8'h04;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b1, 4'hE, 4'hE);
      step();
    end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (LATENCY + 4) step();
    chk("stream_n1", n1, 32'd10);
    chk("stream_run", max_run1, 32'd10);
    chk("stream_n0", n0, 32'd0);
    chk("stream_cnt1", {24'd0, cnt1}, 32'd10);
    chk_data = 1'b0;

    // Two handshakes (req1 then req0), reset before their results return.
    do_reset();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd1);
    step();
    drive(1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("flush_n0", n0, 32'd0);
    chk("flush_n1", n1, 32'd0);
    chk("flush_cnt", {16'd0, cnt0, cnt1}, 32'd0);
    drive(1'b1, 4'd1, 4'd1, 1'b1, 4'd1, 4'd1);
    @(negedge clk);
    chk("flush_tie_ready0", {31'd0, req0_ready}, 32'd1);
    chk("flush_tie_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;

    // 260 req0 results: counter saturates at 255.
    do_reset();
    chk_data = 1'b1;
    exp_data = 8'h01;
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 4'd0);
      step();
    end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    repeat (LATENCY + 4) step();
    chk("sat_n0", n0, 32'd260);
    chk("sat_cnt0", {24'd0, cnt0}, 32'd255);
    chk("sat_cnt1", {24'd0, cnt1}, 32'd0);
    chk_data = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 3: clock edges from operands driven on mul_a/mul_b to the valid product on mul_res; legal range 1..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, requester n presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 4 each, signed two's-complement operands.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 each, grant; a handshake occurs when valid and ready are both high.
REQ-007 SHALL have ports mul_a and mul_b, output, 4 each, registered operands to the shared pipelined multiplier.
REQ-008 SHALL have port mul_res, input, 8, signed product returned by the multiplier.
REQ-009 SHALL have ports rsp0_valid and rsp1_valid, output, 1 each, one-cycle result strobe per requester.
REQ-010 SHALL have port rsp_data, output, 8, registered product, meaningful only while a rsp valid is high.
REQ-011 SHALL have ports cnt0 and cnt1, output, 8 each, completed-result counters, saturating at 255.

Function
REQ-012 SHALL assert at most one of req0_ready/req1_ready per cycle; ready is combinational from valid and the priority pointer.
REQ-013 SHALL grant the only valid requester when exactly one requester is valid, every cycle, with no bubbles.
REQ-014 SHALL use round-robin when both are valid: grant the requester not granted most recently; the pointer updates only on a handshake.
REQ-015 SHALL load the granted requester's operands into mul_a/mul_b on the handshake edge, and load 0/0 on an edge with no handshake.
REQ-016 SHALL shift a tag {valid, id} for each handshake through a LATENCY-deep register chain aligned with the multiplier pipeline.
REQ-017 SHALL, when the tag exits the chain, register mul_res into rsp_data and pulse rsp<id>_valid for one cycle.
REQ-018 SHALL produce a total latency of LATENCY+1 edges from a handshake at edge N: rsp valid is high after edge N+LATENCY+1.
REQ-019 SHALL sustain one result per cycle, returning results strictly in issue order; rsp0_valid and rsp1_valid are never high together.
REQ-020 SHALL hold rsp_data at its last value while no rsp valid is high.
REQ-021 SHALL increment cnt<id> on each rsp<id>_valid pulse, saturating at 255 (no wrap).
REQ-022 SHALL never apply backpressure on the response side; requesters must accept rsp pulses.

Reset
REQ-023 SHALL, with rst high at an edge: clear all tags, set mul_a=mul_b=0, rsp_data=0, rsp0_valid=rsp1_valid=0, cnt0=cnt1=0, and point the pointer so req0 wins the first tie.
REQ-024 SHALL force req0_ready=req1_ready=0 while rst is high.
REQ-025 SHALL discard operations in flight when rst is asserted mid-operation; no rsp pulse is ever produced for them, even if mul_res later changes.

Verification
REQ-026 SHALL be verified by: req0 only, a=3 b=4, LATENCY=3, handshake at edge 1 -> rsp0_valid high after edge 5 only, rsp_data=0x0C, cnt0=1.
REQ-027 SHALL be verified by: both valid for 4 cycles, req0 a=-1 b=-1, req1 a=-1 b=1 -> grants alternate 0,1,0,1; rsp_data alternates 0x01 and 0xFF on consecutive cycles, with matching ids.
REQ-028 SHALL be verified by: req1 streams a=-2 b=-2 for 10 cycles -> 10 back-to-back rsp1_valid pulses, rsp_data=0x04 each, cnt1=10.
REQ-029 SHALL be verified by: rst pulsed one cycle after two handshakes -> no rsp pulses, counters 0, and the next tie grants req0.
REQ-030 SHALL be verified by: 260 completed req0 results -> cnt0 holds at 255.
REQ-031 SHALL be verified by: a single-requester tie edge case, req1 valid alone after a req1 grant -> req1 is granted again immediately.
